cdc_rx_fifo: RTL and testbench

CDC_RX_FIFO -- requirements
Module: cdc_rx_fifo

---
 rtl/cdc_pkg.sv | 8 +
 rtl/cdc_rx_fifo.sv | 69 ++++++
 tb/tb_cdc_rx_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared payload type and depth for the CDC receive path
package cdc_pkg;

    typedef logic [31:0] cdc_data_t;

    localparam int CDC_RX_FIFO_DEPTH = 4;

endpackage

// File: rtl/cdc_rx_fifo.sv
// rtl/cdc_rx_fifo.sv - registered-output receive FIFO behind the CDC handshake stage
module cdc_rx_fifo
    import cdc_pkg::*;
#(
    parameter type T     = cdc_data_t,
    parameter int  DEPTH = CDC_RX_FIFO_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  T                       data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output T                       data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [$clog2(DEPTH):0] usage_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cdc_rx_fifo: DEPTH must be a power of two and at least 2");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        push;
    logic        pop;

    // Status flags come only from the registered pointers, so ready_o never depends on ready_i.
    always_comb begin
        full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty_o = (wr_ptr == rd_ptr);
        ready_o = !full_o;
        valid_o = !empty_o;
        usage_o = wr_ptr - rd_ptr;
        data_o  = mem[rd_ptr[AW-1:0]];
        push    = valid_i && ready_o && !flush_i && !rst_i;
        pop     = valid_o && ready_i && !flush_i && !rst_i;
    end

    // Pointer update; reset and flush both clear the queue and override any transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents survive reset and flush, only the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: tb/tb_cdc_rx_fifo.sv
// tb/tb_cdc_rx_fifo.sv - directed and scoreboard bench for cdc_rx_fifo
module tb_cdc_rx_fifo;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [2:0]  usage_o;
    logic        full_o;
    logic        empty_o;

    int errors = 0;
    int checks = 0;

    cdc_rx_fifo #(.T(logic [31:0]), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .usage_o (usage_o),
        .full_o  (full_o),
        .empty_o (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid cycle %0d got %b want 0", c, valid_o); end
            checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready cycle %0d got %b want 1", c, ready_o); end
            checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL reset_usage cycle %0d got %0d want 0", c, usage_o); end
            checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty cycle %0d got %b want 1", c, empty_o); end
            checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full cycle %0d got %b want 0", c, full_o); end
            step();
        end
    endtask

    task automatic test_fill_full();
        logic [31:0] vals [5];
        vals = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_i  = vals[i];
            valid_i = 1'b1;
            checks++;
            if (ready_o !== (i < 4)) begin errors++; $display("FAIL fill_ready word %0d got %b want %b", i, ready_o, (i < 4)); end
            if (i < 4) step();
        end
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full_o); end
        checks++; if (usage_o !== 3'd4) begin errors++; $display("FAIL fill_usage got %0d want 4", usage_o); end
        checks++; if (data_o !== 32'h11) begin errors++; $display("FAIL fill_head got %h want 11", data_o); end
        step();
        checks++; if (usage_o !== 3'd4) begin errors++; $display("FAIL fill_refused usage got %0d want 4", usage_o); end
    endtask

    task automatic test_drain();
        logic [31:0] expv [5];
        expv = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        ready_i = 1'b1;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL drain_ready_full got %b want 0", ready_o); end
        checks++; if (data_o !== expv[0]) begin errors++; $display("FAIL drain_word0 got %h want %h", data_o, expv[0]); end
        step();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL drain_ready_after_pop got %b want 1", ready_o); end
        checks++; if (usage_o !== 3'd3) begin errors++; $display("FAIL drain_usage_after_pop got %0d want 3", usage_o); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (valid_o !== 1'b1 || data_o !== expv[i]) begin errors++; $display("FAIL drain_word%0d got %b/%h want 1/%h", i, valid_o, data_o, expv[i]); end
            step();
            valid_i = 1'b0;
        end
        checks++; if (empty_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %b/%b want 1/0", empty_o, valid_o); end
    endtask

    task automatic test_back_to_back();
        int rx = 0;
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_i  = i;
            valid_i = 1'b1;
            if (valid_o) begin
                checks++; if (data_o !== rx) begin errors++; $display("FAIL stream_order got %0d want %0d", data_o, rx); end
                rx++;
            end
            step();
            checks++; if (usage_o !== 3'd1) begin errors++; $display("FAIL stream_usage word %0d got %0d want 1", i, usage_o); end
        end
        valid_i = 1'b0;
        if (valid_o) begin
            checks++; if (data_o !== rx) begin errors++; $display("FAIL stream_order got %0d want %0d", data_o, rx); end
            rx++;
        end
        step();
        checks++; if (rx != 20) begin errors++; $display("FAIL stream_count got %0d want 20", rx); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL stream_empty got %b want 1", empty_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_i  = 32'hA1 + i;
            valid_i = 1'b1;
            step();
        end
        checks++; if (usage_o !== 3'd3) begin errors++; $display("FAIL flush_load got %0d want 3", usage_o); end
        flush_i = 1'b1;
        data_i  = 32'hAA;
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", ready_o); end
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        checks++; if (usage_o !== 3'd0) begin errors++; $display("FAIL flush_usage got %0d want 0", usage_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", valid_o); end
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale cycle %0d got %b/%h want 0", c, valid_o, data_o); end
            step();
        end
        data_i  = 32'h5A;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h5A) begin errors++; $display("FAIL flush_next got %b/%h want 1/5a", valid_o, data_o); end
        step();
    endtask

    task automatic test_random();
        logic [31:0] q [$];
        logic        do_push;
        logic        do_pop;
        logic [31:0] want;
        for (int c = 0; c < 1000; c++) begin
            rst_i   = (c == 500);
            valid_i = ($urandom_range(0, 99) < 60);
            ready_i = ($urandom_range(0, 99) < 50);
            data_i  = $urandom;
            checks++; if (ready_o !== (q.size() < DEPTH)) begin errors++; $display("FAIL rand_ready cycle %0d got %b want %b", c, ready_o, (q.size() < DEPTH)); end
            checks++; if (valid_o !== (q.size() > 0)) begin errors++; $display("FAIL rand_valid cycle %0d got %b want %b", c, valid_o, (q.size() > 0)); end
            checks++; if (usage_o !== q.size()) begin errors++; $display("FAIL rand_usage cycle %0d got %0d want %0d", c, usage_o, q.size()); end
            if (q.size() > 0) begin
                want = q[0];
                checks++; if (data_o !== want) begin errors++; $display("FAIL rand_data cycle %0d got %h want %h", c, data_o, want); end
            end
            do_push = valid_i && (q.size() < DEPTH) && !rst_i;
            do_pop  = ready_i && (q.size() > 0) && !rst_i;
            if (rst_i) q.delete();
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(data_i);
            step();
            if (c == 500) begin
                checks++; if (empty_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL rand_after_reset got %b/%b want 1/0", empty_o, valid_o); end
            end
        end
        rst_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_drain();
        test_back_to_back();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
